rv_branch_unit: RTL and testbench
=================================

// Module: rv_branch_unit
// PURPOSE
// RV32I conditional-branch resolver for the single-cycle core's execute stage.
// Compares rs1/rs2 per funct3 and drives BranchTaken combinationally to PC-select logic.
// Also computes the branch target.
// Provides a one-cycle registered copy of {taken, target, flags} for trace/debug.
// PARAMETERS
// XLEN  32  operand, PC and immediate width
// PORTS
// clk          in   1     rising-edge clock (registered stage only)
// rst          in   1     synchronous, active-high reset
// valid_in     in   1     current instruction is a B-type branch
// rs1          in   XLEN  source operand 1
// rs2          in   XLEN  source operand 2
// funct3       in   3     branch condition select
// pc           in   XLEN  PC of the branch instruction
// imm          in   XLEN  sign-extended B-immediate (bit0 already 0)
// BranchTaken  out  1     combinational condition result
// target       out  XLEN  combinational pc+imm
// taken_q      out  1     registered (valid_in & BranchTaken)
// target_q     out  XLEN  registered target
// valid_q      out  1     registered valid_in
// illegal_q    out  1     registered: valid_in with funct3 010/011
// misalign_q   out  1     registered: taken with target[1:0]!=0
// BEHAVIOUR
// - One clock (clk); reset is synchronous and active-high (rst).
// - BranchTaken is purely combinational from rs1/rs2/funct3 and does not depend on valid_in, clk or rst.
// - funct3 decode:
//   - 000 BEQ: rs1==rs2
//   - 001 BNE: rs1!=rs2
//   - 100 BLT: $signed(rs1)<$signed(rs2)
//   - 101 BGE: $signed(rs1)>=$signed(rs2)
//   - 110 BLTU: unsigned rs1<rs2
//   - 111 BGEU: unsigned rs1>=rs2
//   - 010/011 (reserved): BranchTaken=0
// - target = pc+imm, truncated to XLEN (wraps modulo 2^XLEN, no overflow flag).
// - Registered stage, latency 1 cycle, updates every posedge:
//   - valid_q <= valid_in
//   - taken_q <= valid_in & BranchTaken
//   - target_q <= target
//   - illegal_q <= valid_in & (funct3==010 | funct3==011)
//   - misalign_q <= valid_in & BranchTaken & (target[1:0]!=0)
// - Reset (rst=1 at posedge) clears valid_q, taken_q, target_q, illegal_q and misalign_q to 0.
//   - Reset wins over simultaneous valid_in.
//   - Combinational outputs are unaffected by rst.
// - No handshake/backpressure; a new branch may be presented every cycle.
// - X-free: every funct3 value yields a defined BranchTaken.
// TESTING
// - BEQ: rs1=10, rs2=10 -> 1; rs1=10, rs2=5 -> 0.
//   BNE: rs1=10, rs2=5 -> 1; rs1=20, rs2=20 -> 0.
// - BLT: rs1=-5, rs2=3 -> 1; rs1=5, rs2=-3 -> 0.
//   BGE: rs1=10, rs2=10 -> 1; rs1=-1, rs2=-2 -> 1.
// - BLTU: 5 vs 0xA -> 1; 0xFFFFFFF0 vs 0xA -> 0.
//   BGEU: 0xA vs 0xA -> 1; 0xFFFFFFFF vs 1 -> 1.
// - Reserved funct3=011, rs1=1, rs2=2, valid_in=1 -> BranchTaken=0; next cycle illegal_q=1, taken_q=0.
// - pc=0xFFFFFFFC, imm=8, BEQ equal, valid_in=1 -> target=0x00000004; next cycle taken_q=1, target_q=4.
//   imm=6 -> misalign_q=1.
// - rst=1 together with valid_in=1 on a taken branch -> all *_q = 0 next cycle; BranchTaken stays 1 throughout.

Source files
------------

// File: rtl/rv_branch_unit.sv
// RV32I conditional-branch resolver: combinational taken/target for PC select,
// plus a one-cycle registered copy of the result and status flags for trace/debug.
module rv_branch_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            BranchTaken,
    output logic [XLEN-1:0] target,
    output logic            taken_q,
    output logic [XLEN-1:0] target_q,
    output logic            valid_q,
    output logic            illegal_q,
    output logic            misalign_q
);

    typedef enum logic [2:0] {
        F3Beq  = 3'b000,
        F3Bne  = 3'b001,
        F3Rsv2 = 3'b010,
        F3Rsv3 = 3'b011,
        F3Blt  = 3'b100,
        F3Bge  = 3'b101,
        F3Bltu = 3'b110,
        F3Bgeu = 3'b111
    } funct3_e;

    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            reserved;
    logic            taken_d;
    logic            illegal_d;
    logic            misalign_d;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    // Reserved encodings resolve to not-taken so the output is never X.
    always_comb begin
        BranchTaken = 1'b0;
        reserved    = 1'b0;
        unique case (funct3_e'(funct3))
            F3Beq:  BranchTaken = eq;
            F3Bne:  BranchTaken = ~eq;
            F3Blt:  BranchTaken = lt_s;
            F3Bge:  BranchTaken = ~lt_s;
            F3Bltu: BranchTaken = lt_u;
            F3Bgeu: BranchTaken = ~lt_u;
            F3Rsv2, F3Rsv3: reserved = 1'b1;
            default: begin
                BranchTaken = 1'b0;
                reserved    = 1'b0;
            end
        endcase
    end

    // Wraps modulo 2^XLEN; the carry out is intentionally dropped.
    assign target = pc + imm;

    always_comb begin
        taken_d    = valid_in & BranchTaken;
        illegal_d  = valid_in & reserved;
        misalign_d = taken_d & (target[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= '0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            valid_q    <= valid_in;
            taken_q    <= taken_d;
            target_q   <= target;
            illegal_q  <= illegal_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_rv_branch_unit.sv
// Self-checking bench for rv_branch_unit: directed vector table, hand-written
// registered-stage corner cases, and randomized stimulus against a reference model.
module tb_rv_branch_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in;
    logic [XLEN-1:0] rs1, rs2, pc, imm;
    logic [2:0]      funct3;
    logic            BranchTaken;
    logic [XLEN-1:0] target;
    logic            taken_q, valid_q, illegal_q, misalign_q;
    logic [XLEN-1:0] target_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv_branch_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .pc         (pc),
        .imm        (imm),
        .BranchTaken(BranchTaken),
        .target     (target),
        .taken_q    (taken_q),
        .target_q   (target_q),
        .valid_q    (valid_q),
        .illegal_q  (illegal_q),
        .misalign_q (misalign_q)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: compare as 64-bit integers (signed via sign extension).
    function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [31:0] i);
        longint s;
        s = ({32'd0, p} + {32'd0, i}) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    task automatic drive(input logic v, input logic r, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i);
        valid_in = v;
        rst      = r;
        funct3   = f;
        rs1      = a;
        rs2      = b;
        pc       = p;
        imm      = i;
    endtask

    // Called just after a negedge with inputs driven; checks comb, clocks, checks regs.
    task automatic cycle(input string tag);
        bit          e_tk, e_v, e_t, e_il, e_mis;
        logic [31:0] e_tgt, e_tgt_q;
        #1;
        e_tk  = ref_taken(funct3, rs1, rs2);
        e_tgt = ref_target(pc, imm);
        chk({tag, ".BranchTaken"}, {31'd0, BranchTaken}, {31'd0, e_tk});
        chk({tag, ".target"}, target, e_tgt);
        e_v     = !rst && valid_in;
        e_t     = e_v && e_tk;
        e_il    = e_v && (funct3 == 3'd2 || funct3 == 3'd3);
        e_mis   = e_t && (e_tgt % 4 != 0);
        e_tgt_q = rst ? 32'd0 : e_tgt;
        @(posedge clk);
        #1;
        chk({tag, ".valid_q"}, {31'd0, valid_q}, {31'd0, e_v});
        chk({tag, ".taken_q"}, {31'd0, taken_q}, {31'd0, e_t});
        chk({tag, ".target_q"}, target_q, e_tgt_q);
        chk({tag, ".illegal_q"}, {31'd0, illegal_q}, {31'd0, e_il});
        chk({tag, ".misalign_q"}, {31'd0, misalign_q}, {31'd0, e_mis});
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        bit          exp_taken;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{3'd0, 32'd10, 32'd10, 1'b1};
        vecs[1]  = '{3'd0, 32'd10, 32'd5, 1'b0};
        vecs[2]  = '{3'd1, 32'd10, 32'd5, 1'b1};
        vecs[3]  = '{3'd1, 32'd20, 32'd20, 1'b0};
        vecs[4]  = '{3'd4, 32'hFFFF_FFFB, 32'd3, 1'b1};
        vecs[5]  = '{3'd4, 32'd5, 32'hFFFF_FFFD, 1'b0};
        vecs[6]  = '{3'd5, 32'd10, 32'd10, 1'b1};
        vecs[7]  = '{3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vecs[8]  = '{3'd6, 32'd5, 32'hA, 1'b1};
        vecs[9]  = '{3'd6, 32'hFFFF_FFF0, 32'hA, 1'b0};
        vecs[10] = '{3'd7, 32'hA, 32'hA, 1'b1};
        vecs[11] = '{3'd7, 32'hFFFF_FFFF, 32'd1, 1'b1};
        vecs[12] = '{3'd2, 32'd7, 32'd7, 1'b0};
        vecs[13] = '{3'd3, 32'd1, 32'd2, 1'b0};
        vecs[14] = '{3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};

        drive(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset.valid_q", {31'd0, valid_q}, 32'd0);
        chk("reset.taken_q", {31'd0, taken_q}, 32'd0);
        chk("reset.target_q", target_q, 32'd0);
        chk("reset.illegal_q", {31'd0, illegal_q}, 32'd0);
        chk("reset.misalign_q", {31'd0, misalign_q}, 32'd0);
        @(negedge clk);

        for (int k = 0; k < 15; k++) begin
            drive(1'b1, 1'b0, vecs[k].f3, vecs[k].a, vecs[k].b, 32'h100, 32'h20);
            #1;
            chk($sformatf("vec%0d.taken", k), {31'd0, BranchTaken}, {31'd0, vecs[k].exp_taken});
            cycle($sformatf("vec%0d", k));
        end

        // Reserved funct3 flagged illegal and never taken.
        drive(1'b1, 1'b0, 3'd3, 32'd1, 32'd2, 32'h200, 32'h10);
        #1;
        chk("rsv.BranchTaken", {31'd0, BranchTaken}, 32'd0);
        @(posedge clk);
        #1;
        chk("rsv.illegal_q", {31'd0, illegal_q}, 32'd1);
        chk("rsv.taken_q", {31'd0, taken_q}, 32'd0);
        @(negedge clk);

        // Target wraps past 2^32.
        drive(1'b1, 1'b0, 3'd0, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'd8);
        #1;
        chk("wrap.target", target, 32'h0000_0004);
        @(posedge clk);
        #1;
        chk("wrap.taken_q", {31'd0, taken_q}, 32'd1);
        chk("wrap.target_q", target_q, 32'd4);
        chk("wrap.misalign_q", {31'd0, misalign_q}, 32'd0);
        @(negedge clk);

        drive(1'b1, 1'b0, 3'd0, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'd6);
        @(posedge clk);
        #1;
        chk("mis.misalign_q", {31'd0, misalign_q}, 32'd1);
        chk("mis.target_q", target_q, 32'd2);
        @(negedge clk);

        // Not-taken with misaligned target must not flag misalign.
        drive(1'b1, 1'b0, 3'd1, 32'd9, 32'd9, 32'h0, 32'd6);
        cycle("mis_nt");

        // Reset beats a simultaneous taken branch; comb path unaffected.
        drive(1'b1, 1'b1, 3'd0, 32'd3, 32'd3, 32'h1000, 32'h40);
        #1;
        chk("rstw.BranchTaken_pre", {31'd0, BranchTaken}, 32'd1);
        @(posedge clk);
        #1;
        chk("rstw.BranchTaken_post", {31'd0, BranchTaken}, 32'd1);
        chk("rstw.target", target, 32'h1040);
        chk("rstw.valid_q", {31'd0, valid_q}, 32'd0);
        chk("rstw.taken_q", {31'd0, taken_q}, 32'd0);
        chk("rstw.target_q", target_q, 32'd0);
        chk("rstw.illegal_q", {31'd0, illegal_q}, 32'd0);
        chk("rstw.misalign_q", {31'd0, misalign_q}, 32'd0);
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b, p, i;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = $urandom;
                2: begin
                    a = $urandom_range(0, 7);
                    b = $urandom_range(0, 7);
                end
                default: b = a ^ 32'h8000_0000;
            endcase
            p = $urandom & 32'hFFFF_FFFC;
            i = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFE)
                                            : (32'($urandom_range(0, 15)) << 1);
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  3'($urandom_range(0, 7)), a, b, p, i);
            cycle($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
